// File: rtl/ime_pkg.sv
// Shared types and constants for the IME stream arbiter: arbiter states,
// frame-owner encoding and the tuser marker carried by a flush beat.
package ime_pkg;

  // State encoding doubles as the arb_owner status value.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    HOST  = 2'b01,
    BIST  = 2'b10,
    FLUSH = 2'b11
  } arb_state_e;

  localparam logic OWNER_HOST = 1'b0;
  localparam logic OWNER_BIST = 1'b1;

  localparam logic [7:0] IME_FLUSH_TUSER = 8'hFF;

endpackage

// File: rtl/ime_tag_fifo.sv
// One-bit frame-owner FIFO: an entry is pushed per launched frame and popped
// when that frame's last accumulator beat comes back.
module ime_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       din_i,
  input  logic                       pop_i,
  output logic                       head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == CW'(0));
  assign count_o   = count_q;
  assign head_o    = mem_q[rd_ptr_q];
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;

  // Storage, pointers (wrap naturally, DEPTH is a power of two) and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ime_stream_arb.sv
// Frame-granular host/BIST arbiter in front of the IME datapath, with
// owner-tagged routing of accumulator results. Optional frame counters are
// built when IME_ARB_STATS_EN is defined.
module ime_stream_arb
  import ime_pkg::*;
#(
  parameter int W_DATA    = 48,
  parameter int W_ACC     = 32,
  parameter int TAG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_DATA-1:0] host_tdata,
  input  logic [7:0]        host_tuser,
  input  logic              host_tvalid,
  input  logic              host_tlast,
  output logic              host_tready,
  input  logic              bist_active,
  input  logic [W_DATA-1:0] bist_tdata,
  input  logic [7:0]        bist_tuser,
  input  logic              bist_tvalid,
  input  logic              bist_tlast,
  output logic              bist_tready,
  output logic [W_DATA-1:0] m_tdata,
  output logic [7:0]        m_tuser,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  input  logic [W_ACC-1:0]  acc_data,
  input  logic [7:0]        acc_tuser,
  input  logic              acc_valid,
  input  logic              acc_last,
  output logic [W_ACC-1:0]  host_acc_data,
  output logic [7:0]        host_acc_tuser,
  output logic              host_acc_valid,
  output logic              host_acc_last,
  output logic [W_ACC-1:0]  obs_acc,
  output logic [7:0]        obs_tuser,
  output logic              obs_valid,
  output logic              obs_last,
  output logic [1:0]        arb_owner,
  output logic              tag_full,
  output logic              tag_err,
  input  logic              clr_err,
  input  logic              stat_clr,
  output logic [15:0]       host_frame_cnt,
  output logic [15:0]       bist_frame_cnt
);

  localparam int CW = $clog2(TAG_DEPTH) + 1;

  arb_state_e      state_q, state_d;
  logic            frame_open_q, frame_open_d;
  logic            tag_err_q, tag_err_d;
  logic            gate_s;
  logic            beat_acc_s;
  logic            push_s;
  logic            pop_s;
  logic            err_s;
  logic            tag_head_s;
  logic            tag_full_s;
  logic            tag_empty_s;
  logic [CW-1:0]   tag_count_s;

  // A frame may only start when its tag has room; open frames always flow.
  assign gate_s     = frame_open_q | (tag_count_s != CW'(TAG_DEPTH));
  assign beat_acc_s = m_tvalid & m_tready;
  assign push_s     = beat_acc_s & ~frame_open_q & (state_q != FLUSH);
  assign pop_s      = acc_valid & acc_last & ~tag_empty_s;
  assign err_s      = acc_valid & tag_empty_s;

  ime_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .din_i   ((state_q == BIST) ? OWNER_BIST : OWNER_HOST),
    .pop_i   (pop_s),
    .head_o  (tag_head_s),
    .count_o (tag_count_s),
    .full_o  (tag_full_s),
    .empty_o (tag_empty_s)
  );

  // Next-state and stream steering.
  always_comb begin
    state_d     = state_q;
    m_tvalid    = 1'b0;
    m_tdata     = '0;
    m_tuser     = 8'h00;
    m_tlast     = 1'b0;
    host_tready = 1'b0;
    bist_tready = 1'b0;
    case (state_q)
      IDLE: begin
        if (bist_active) begin
          state_d = BIST;
        end else if (host_tvalid) begin
          state_d = HOST;
        end else begin
          state_d = IDLE;
        end
      end
      HOST: begin
        m_tvalid    = host_tvalid & gate_s;
        m_tdata     = host_tdata;
        m_tuser     = host_tuser;
        m_tlast     = host_tlast;
        host_tready = m_tready & gate_s;
        if (host_tvalid && gate_s && m_tready && host_tlast) begin
          state_d = IDLE;
        end else begin
          state_d = HOST;
        end
      end
      BIST: begin
        if (bist_active) begin
          m_tvalid    = bist_tvalid & gate_s;
          m_tdata     = bist_tdata;
          m_tuser     = bist_tuser;
          m_tlast     = bist_tlast;
          bist_tready = m_tready & gate_s;
          state_d     = BIST;
        end else if (frame_open_q) begin
          state_d = FLUSH;
        end else begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        // Terminates the aborted BIST frame; its tag was pushed at frame start.
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        m_tuser  = IME_FLUSH_TUSER;
        if (m_tready) begin
          state_d = IDLE;
        end else begin
          state_d = FLUSH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame tracking and sticky error next-state; a new error beats a clear.
  always_comb begin
    frame_open_d = frame_open_q;
    tag_err_d    = tag_err_q;
    if (beat_acc_s) begin
      frame_open_d = ~m_tlast;
    end else begin
      frame_open_d = frame_open_q;
    end
    if (err_s) begin
      tag_err_d = 1'b1;
    end else if (clr_err) begin
      tag_err_d = 1'b0;
    end else begin
      tag_err_d = tag_err_q;
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      frame_open_q <= 1'b0;
      tag_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_open_q <= frame_open_d;
      tag_err_q    <= tag_err_d;
    end
  end

  assign arb_owner = state_q;
  assign tag_full  = tag_full_s;
  assign tag_err   = tag_err_q;

  // Results follow the owner of the oldest outstanding frame.
  assign host_acc_data  = acc_data;
  assign host_acc_tuser = acc_tuser;
  assign host_acc_last  = acc_last;
  assign host_acc_valid = acc_valid & ~tag_empty_s & (tag_head_s == OWNER_HOST);
  assign obs_acc        = acc_data;
  assign obs_tuser      = acc_tuser;
  assign obs_last       = acc_last;
  assign obs_valid      = acc_valid & ~tag_empty_s & (tag_head_s == OWNER_BIST);

`ifdef IME_ARB_STATS_EN
  logic [15:0] host_cnt_q;
  logic [15:0] bist_cnt_q;
  logic        host_inc_s;
  logic        bist_inc_s;

  assign host_inc_s = beat_acc_s & m_tlast & (state_q == HOST);
  assign bist_inc_s = beat_acc_s & m_tlast & ((state_q == BIST) | (state_q == FLUSH));

  // Saturating completed-frame counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_cnt_q <= 16'h0000;
      bist_cnt_q <= 16'h0000;
    end else if (stat_clr) begin
      host_cnt_q <= 16'h0000;
      bist_cnt_q <= 16'h0000;
    end else begin
      if (host_inc_s && (host_cnt_q != 16'hFFFF)) begin
        host_cnt_q <= host_cnt_q + 16'd1;
      end
      if (bist_inc_s && (bist_cnt_q != 16'hFFFF)) begin
        bist_cnt_q <= bist_cnt_q + 16'd1;
      end
    end
  end

  assign host_frame_cnt = host_cnt_q;
  assign bist_frame_cnt = bist_cnt_q;
`else
  logic unused_stat_clr_s;

  assign unused_stat_clr_s = stat_clr;
  assign host_frame_cnt    = 16'h0000;
  assign bist_frame_cnt    = 16'h0000;
`endif

endmodule

// File: tb/tb_ime_stream_arb.sv
// Scoreboard bench for ime_stream_arb: stream beats and routed results are
// queued when driven and popped by a negedge monitor; tasks check control state.
module tb_ime_stream_arb;

  logic        clk, rst_n;
  logic [47:0] host_tdata, bist_tdata, m_tdata;
  logic [7:0]  host_tuser, bist_tuser, m_tuser;
  logic        host_tvalid, host_tlast, host_tready;
  logic        bist_active, bist_tvalid, bist_tlast, bist_tready;
  logic        m_tvalid, m_tlast, m_tready;
  logic [31:0] acc_data, host_acc_data, obs_acc;
  logic [7:0]  acc_tuser, host_acc_tuser, obs_tuser;
  logic        acc_valid, acc_last, host_acc_valid, host_acc_last, obs_valid, obs_last;
  logic [1:0]  arb_owner;
  logic        tag_full, tag_err, clr_err, stat_clr;
  logic [15:0] host_frame_cnt, bist_frame_cnt;

  int total = 0;
  int bad   = 0;
  int host_done = 0;
  int bist_done = 0;
  bit host_quiet = 1'b0;

  logic [56:0] exp_m[$];
  logic [40:0] exp_host[$];
  logic [40:0] exp_obs[$];

  ime_stream_arb dut (
    .clk(clk), .rst_n(rst_n),
    .host_tdata(host_tdata), .host_tuser(host_tuser), .host_tvalid(host_tvalid),
    .host_tlast(host_tlast), .host_tready(host_tready),
    .bist_active(bist_active),
    .bist_tdata(bist_tdata), .bist_tuser(bist_tuser), .bist_tvalid(bist_tvalid),
    .bist_tlast(bist_tlast), .bist_tready(bist_tready),
    .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready),
    .acc_data(acc_data), .acc_tuser(acc_tuser), .acc_valid(acc_valid), .acc_last(acc_last),
    .host_acc_data(host_acc_data), .host_acc_tuser(host_acc_tuser),
    .host_acc_valid(host_acc_valid), .host_acc_last(host_acc_last),
    .obs_acc(obs_acc), .obs_tuser(obs_tuser), .obs_valid(obs_valid), .obs_last(obs_last),
    .arb_owner(arb_owner), .tag_full(tag_full), .tag_err(tag_err),
    .clr_err(clr_err), .stat_clr(stat_clr),
    .host_frame_cnt(host_frame_cnt), .bist_frame_cnt(bist_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every transfer on the three output ports must match the queue head.
  always @(negedge clk) begin
    logic [56:0] em;
    logic [40:0] er;
    if (rst_n) begin
      if (m_tvalid && m_tready) begin
        total++;
        if (exp_m.size() == 0) begin
          bad++;
          $display("FAIL m_beat_unexpected: got %h want none", {m_tdata, m_tuser, m_tlast});
        end else begin
          em = exp_m.pop_front();
          if ({m_tdata, m_tuser, m_tlast} !== em) begin
            bad++;
            $display("FAIL m_beat: got %h want %h", {m_tdata, m_tuser, m_tlast}, em);
          end
        end
      end
      if (host_acc_valid) begin
        total++;
        if (exp_host.size() == 0) begin
          bad++;
          $display("FAIL host_result_unexpected: got %h want none", {host_acc_data, host_acc_tuser, host_acc_last});
        end else begin
          er = exp_host.pop_front();
          if ({host_acc_data, host_acc_tuser, host_acc_last} !== er) begin
            bad++;
            $display("FAIL host_result: got %h want %h", {host_acc_data, host_acc_tuser, host_acc_last}, er);
          end
        end
      end
      if (obs_valid) begin
        total++;
        if (exp_obs.size() == 0) begin
          bad++;
          $display("FAIL obs_result_unexpected: got %h want none", {obs_acc, obs_tuser, obs_last});
        end else begin
          er = exp_obs.pop_front();
          if ({obs_acc, obs_tuser, obs_last} !== er) begin
            bad++;
            $display("FAIL obs_result: got %h want %h", {obs_acc, obs_tuser, obs_last}, er);
          end
        end
      end
      if (host_quiet) begin
        total++;
        if (host_tready !== 1'b0) begin
          bad++;
          $display("FAIL host_tready_quiet: got %b want 0", host_tready);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the selected ready at negedge; returns at posedge+1 after the transfer.
  task automatic wait_ready(input bit is_bist, output int cyc);
    bit acc;
    acc = 1'b0;
    cyc = 0;
    while (!acc && cyc < 50) begin
      @(negedge clk);
      acc = is_bist ? bist_tready : host_tready;
      tick();
      if (!acc) cyc++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got no ready want ready within 50 cycles");
    end
  endtask

  task automatic send_frame(input bit is_bist, input int n, input int nsend,
                            input logic [7:0] tag, input int raise_at, output int first_wait);
    logic [47:0] d;
    logic [7:0]  u;
    logic        l;
    int          cyc;
    first_wait = 0;
    for (int i = 0; i < nsend; i++) begin
      if (i == raise_at) bist_active = 1'b1;
      d = {tag, 8'(i), 32'hC0DE_0000 + 32'(i)};
      u = tag ^ 8'(i);
      l = (i == n - 1);
      if (is_bist) begin
        bist_tdata = d; bist_tuser = u; bist_tlast = l; bist_tvalid = 1'b1;
      end else begin
        host_tdata = d; host_tuser = u; host_tlast = l; host_tvalid = 1'b1;
      end
      exp_m.push_back({d, u, l});
      wait_ready(is_bist, cyc);
      if (i == 0) first_wait = cyc;
      if (l && is_bist) bist_done++;
      if (l && !is_bist) host_done++;
    end
    bist_tvalid = 1'b0;
    host_tvalid = 1'b0;
  endtask

  // dest: 0 host port, 1 observation port, other values neither.
  task automatic send_acc(input logic [31:0] d, input logic [7:0] u, input logic l, input int dest);
    acc_data = d; acc_tuser = u; acc_last = l; acc_valid = 1'b1;
    if (dest == 0) exp_host.push_back({d, u, l});
    if (dest == 1) exp_obs.push_back({d, u, l});
    @(negedge clk);
    total++;
    if (host_acc_valid !== (dest == 0)) begin
      bad++;
      $display("FAIL route_host_valid: got %b want %b", host_acc_valid, (dest == 0));
    end
    total++;
    if (obs_valid !== (dest == 1)) begin
      bad++;
      $display("FAIL route_obs_valid: got %b want %b", obs_valid, (dest == 1));
    end
    tick();
    acc_valid = 1'b0;
    acc_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    host_tdata = '0; host_tuser = '0; host_tvalid = 1'b0; host_tlast = 1'b0;
    bist_active = 1'b0; bist_tdata = '0; bist_tuser = '0; bist_tvalid = 1'b0; bist_tlast = 1'b0;
    m_tready = 1'b1;
    acc_data = '0; acc_tuser = '0; acc_valid = 1'b0; acc_last = 1'b0;
    clr_err = 1'b0; stat_clr = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({m_tvalid, host_tready, bist_tready, host_acc_valid, obs_valid} !== 5'b0) begin
      bad++;
      $display("FAIL reset_valids: got %b want 00000", {m_tvalid, host_tready, bist_tready, host_acc_valid, obs_valid});
    end
    total++;
    if (arb_owner !== 2'b00) begin bad++; $display("FAIL reset_owner: got %b want 00", arb_owner); end
    total++;
    if ({tag_full, tag_err} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {tag_full, tag_err}); end
    total++;
    if ({host_frame_cnt, bist_frame_cnt} !== 32'h0) begin
      bad++;
      $display("FAIL reset_counters: got %h want 0", {host_frame_cnt, bist_frame_cnt});
    end
    tick();
  endtask

  task automatic test_host_frame();
    int w;
    send_frame(1'b0, 3, 3, 8'h11, -1, w);
    total++;
    if (w !== 1) begin bad++; $display("FAIL host_bubble: got %0d want 1", w); end
    send_acc(32'd77, 8'h05, 1'b1, 0);
  endtask

  task automatic test_bist_priority();
    int w;
    bist_active = 1'b1;
    host_tdata = 48'hABCD_0000_1234; host_tuser = 8'h21; host_tlast = 1'b1; host_tvalid = 1'b1;
    @(negedge clk);
    total++;
    if ({arb_owner, host_tready} !== 3'b000) begin bad++; $display("FAIL prio_idle: got %b want 000", {arb_owner, host_tready}); end
    tick();
    @(negedge clk);
    total++;
    if (arb_owner !== 2'b10) begin bad++; $display("FAIL prio_owner: got %b want 10", arb_owner); end
    tick();
    host_quiet = 1'b1;
    send_frame(1'b1, 4, 4, 8'h22, -1, w);
    host_tvalid = 1'b1;
    total++;
    if (w !== 0) begin bad++; $display("FAIL prio_bist_wait: got %0d want 0", w); end
    bist_active = 1'b0;
    host_quiet  = 1'b0;
    exp_m.push_back({48'hABCD_0000_1234, 8'h21, 1'b1});
    wait_ready(1'b0, w);
    host_tvalid = 1'b0;
    host_done++;
    total++;
    if (w !== 2) begin bad++; $display("FAIL prio_host_return: got %0d want 2", w); end
    send_acc(32'h1111_0001, 8'h31, 1'b0, 1);
    send_acc(32'h1111_0002, 8'h32, 1'b1, 1);
    send_acc(32'h2222_0003, 8'h33, 1'b1, 0);
  endtask

  task automatic test_preempt();
    int w;
    send_frame(1'b0, 4, 4, 8'h33, 1, w);
    send_frame(1'b1, 2, 2, 8'h44, -1, w);
    total++;
    if (w !== 1) begin bad++; $display("FAIL preempt_bist_bubble: got %0d want 1", w); end
    bist_active = 1'b0;
    tick();
    tick();
    send_acc(32'h3333_0033, 8'h41, 1'b1, 0);
    send_acc(32'h4444_0044, 8'h42, 1'b1, 1);
  endtask

  task automatic test_flush();
    int w;
    logic [15:0] eb;
    bist_active = 1'b1;
    send_frame(1'b1, 4, 2, 8'h55, -1, w);
    total++;
    if (w !== 1) begin bad++; $display("FAIL flush_bubble: got %0d want 1", w); end
    bist_active = 1'b0;
    exp_m.push_back({48'h0, 8'hFF, 1'b1});
    bist_done++;
    @(negedge clk);
    total++;
    if ({arb_owner, m_tvalid} !== 3'b100) begin bad++; $display("FAIL flush_abort: got %b want 100", {arb_owner, m_tvalid}); end
    tick();
    @(negedge clk);
    total++;
    if ({arb_owner, m_tvalid} !== 3'b111) begin bad++; $display("FAIL flush_beat: got %b want 111", {arb_owner, m_tvalid}); end
    tick();
    @(negedge clk);
    total++;
    if (arb_owner !== 2'b00) begin bad++; $display("FAIL flush_idle: got %b want 00", arb_owner); end
`ifdef IME_ARB_STATS_EN
    eb = 16'(bist_done);
`else
    eb = 16'd0;
`endif
    total++;
    if (bist_frame_cnt !== eb) begin bad++; $display("FAIL flush_count: got %0d want %0d", bist_frame_cnt, eb); end
    tick();
    send_acc(32'h5555_0055, 8'h51, 1'b1, 1);
  endtask

  task automatic test_tag_full();
    int w;
    for (int k = 0; k < 4; k++) send_frame(1'b0, 1, 1, 8'h60 + 8'(k), -1, w);
    host_tdata = 48'h6464_6464_6464; host_tuser = 8'h64; host_tlast = 1'b1; host_tvalid = 1'b1;
    exp_m.push_back({48'h6464_6464_6464, 8'h64, 1'b1});
    @(negedge clk);
    total++;
    if (tag_full !== 1'b1) begin bad++; $display("FAIL full_flag: got %b want 1", tag_full); end
    tick();
    @(negedge clk);
    total++;
    if ({host_tready, m_tvalid, arb_owner} !== 4'b0001) begin
      bad++;
      $display("FAIL full_stall: got %b want 0001", {host_tready, m_tvalid, arb_owner});
    end
    tick();
    acc_data = 32'h6000_0000; acc_tuser = 8'h60; acc_last = 1'b1; acc_valid = 1'b1;
    exp_host.push_back({32'h6000_0000, 8'h60, 1'b1});
    @(negedge clk);
    total++;
    if (host_tready !== 1'b0) begin bad++; $display("FAIL full_same_cycle_pop: got %b want 0", host_tready); end
    tick();
    acc_valid = 1'b0; acc_last = 1'b0;
    @(negedge clk);
    total++;
    if ({host_tready, tag_full} !== 2'b10) begin bad++; $display("FAIL full_release: got %b want 10", {host_tready, tag_full}); end
    tick();
    host_tvalid = 1'b0;
    host_done++;
    for (int k = 1; k < 5; k++) send_acc(32'h6000_0000 + 32'(k), 8'h60 + 8'(k), 1'b1, 0);
  endtask

  task automatic test_tag_err();
    send_acc(32'hDEAD_BEEF, 8'hEE, 1'b1, 2);
    @(negedge clk);
    total++;
    if (tag_err !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", tag_err); end
    tick();
    @(negedge clk);
    total++;
    if (tag_err !== 1'b1) begin bad++; $display("FAIL err_hold: got %b want 1", tag_err); end
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    @(negedge clk);
    total++;
    if (tag_err !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", tag_err); end
    tick();
    clr_err = 1'b1;
    send_acc(32'hBAD0_0001, 8'hE1, 1'b1, 2);
    clr_err = 1'b0;
    @(negedge clk);
    total++;
    if (tag_err !== 1'b1) begin bad++; $display("FAIL err_beats_clear: got %b want 1", tag_err); end
    tick();
  endtask

  task automatic test_stats();
    logic [15:0] eh, eb;
`ifdef IME_ARB_STATS_EN
    eh = 16'(host_done);
    eb = 16'(bist_done);
`else
    eh = 16'd0;
    eb = 16'd0;
`endif
    @(negedge clk);
    total++;
    if ({host_frame_cnt, bist_frame_cnt} !== {eh, eb}) begin
      bad++;
      $display("FAIL stats_counts: got %0d/%0d want %0d/%0d", host_frame_cnt, bist_frame_cnt, eh, eb);
    end
    tick();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    @(negedge clk);
    total++;
    if ({host_frame_cnt, bist_frame_cnt} !== 32'h0) begin
      bad++;
      $display("FAIL stats_clear: got %0d/%0d want 0/0", host_frame_cnt, bist_frame_cnt);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_host_frame();
    test_bist_priority();
    test_preempt();
    test_flush();
    test_tag_full();
    test_tag_err();
    test_stats();
    repeat (2) tick();
    total++;
    if (exp_m.size() != 0) begin bad++; $display("FAIL m_drain: got %0d left want 0", exp_m.size()); end
    total++;
    if (exp_host.size() != 0) begin bad++; $display("FAIL host_drain: got %0d left want 0", exp_host.size()); end
    total++;
    if (exp_obs.size() != 0) begin bad++; $display("FAIL obs_drain: got %0d left want 0", exp_obs.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
